count_display: RTL and testbench

- Downstream consumer of the loadable up/down counter.
- Takes the counter's 8-bit count and done outputs and drives a 4-digit multiplexed common-anode 7-segment display plus a stretched done LED.
- Converts binary to BCD with an iterative double-dabble FSM, then time-multiplexes the digits.

---
 rtl/countdisp_pkg.sv | 47 ++++
 rtl/count_display_bcd_conv.sv | 49 ++++
 rtl/count_display.sv | 124 ++++++++++++
 tb/tb_count_display.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/countdisp_pkg.sv
// Shared types and constants for the count_display block: FSM states,
// active-low 7-segment codes, digit positions and the BCD width.
package countdisp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } cd_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    localparam int DIG_ONES  = 0;
    localparam int DIG_TENS  = 1;
    localparam int DIG_HUNDS = 2;
    localparam int DIG_SIGN  = 3;

    localparam int BCD_W = 12;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = SEG_0;
            4'd1:    seg_of = SEG_1;
            4'd2:    seg_of = SEG_2;
            4'd3:    seg_of = SEG_3;
            4'd4:    seg_of = SEG_4;
            4'd5:    seg_of = SEG_5;
            4'd6:    seg_of = SEG_6;
            4'd7:    seg_of = SEG_7;
            4'd8:    seg_of = SEG_8;
            4'd9:    seg_of = SEG_9;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/count_display_bcd_conv.sv
// Iterative 8-bit double-dabble converter: loads on start, then performs
// one add-3/shift step per cycle for 8 cycles.
module bcd_conv
    import countdisp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done_conv
);

    logic [BCD_W+7:0] sr;
    logic [BCD_W+7:0] sr_nxt;
    logic [2:0]       step;
    logic             active;

    always_comb begin
        sr_nxt = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr_nxt[8+4*i +: 4] >= 4'd5)
                sr_nxt[8+4*i +: 4] = sr_nxt[8+4*i +: 4] + 4'd3;
        end
        sr_nxt = {sr_nxt[BCD_W+6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr     <= '0;
            step   <= 3'd0;
            active <= 1'b0;
        end else if (start) begin
            sr     <= {{BCD_W{1'b0}}, bin};
            step   <= 3'd0;
            active <= 1'b1;
        end else if (active) begin
            sr   <= sr_nxt;
            step <= step + 3'd1;
            if (step == 3'd7)
                active <= 1'b0;
        end
    end

    assign bcd = sr[BCD_W+7:8];
    // High during the cycle whose closing edge performs the final shift.
    assign done_conv = active && (step == 3'd7);

endmodule

// File: rtl/count_display.sv
// 4-digit multiplexed 7-segment driver for the counter value plus a stretched
// done LED. Define COUNTDISP_SIGNED_EN to treat count as two's complement.
module count_display
    import countdisp_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DONE_STRETCH = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       done,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       done_led,
    output logic       busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int TW = (DONE_STRETCH > 1) ? $clog2(DONE_STRETCH) : 1;

    cd_state_t         state;
    logic [7:0]        last_val;
    logic              force_conv;
    logic [7:0]        mag;
    logic              start;
    logic [BCD_W-1:0]  bcd;
    logic              done_conv;
    logic [3:0][6:0]   disp;
    logic [SW-1:0]     scan_cnt;
    logic [1:0]        idx;
    logic [TW-1:0]     timer;

`ifdef COUNTDISP_SIGNED_EN
    // 8-bit negate keeps -128 as 128 when read unsigned.
    assign mag = count[7] ? (~count + 8'd1) : count;
`else
    assign mag = count;
`endif

    assign start = (state == ST_IDLE) && (force_conv || (count != last_val));

    bcd_conv u_conv (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (mag),
        .bcd       (bcd),
        .done_conv (done_conv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_val   <= 8'd0;
            force_conv <= 1'b1;
            busy       <= 1'b0;
            disp       <= {4{SEG_BLANK}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_val   <= count;
                        force_conv <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (done_conv)
                        state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    disp[DIG_ONES]  <= seg_of(bcd[3:0]);
                    disp[DIG_TENS]  <= (bcd[11:4] == 8'd0) ? SEG_BLANK : seg_of(bcd[7:4]);
                    disp[DIG_HUNDS] <= (bcd[11:8] == 4'd0) ? SEG_BLANK : seg_of(bcd[11:8]);
`ifdef COUNTDISP_SIGNED_EN
                    disp[DIG_SIGN]  <= last_val[7] ? SEG_MINUS : SEG_BLANK;
`else
                    disp[DIG_SIGN]  <= SEG_BLANK;
`endif
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // an/seg follow the index held during this cycle, so digit 0 lights
    // on the first edge after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            seg      <= SEG_BLANK;
            an       <= 4'hF;
        end else begin
            seg <= disp[idx];
            an  <= ~(4'b0001 << idx);
            if (scan_cnt == SW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer    <= '0;
            done_led <= 1'b0;
        end else if (done) begin
            timer    <= TW'(DONE_STRETCH - 1);
            done_led <= 1'b1;
        end else begin
            done_led <= (timer != '0);
            if (timer != '0)
                timer <= timer - 1'b1;
        end
    end

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with SCAN_DIV=4, DONE_STRETCH=6.
module tb_count_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] count;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;
    logic       done_led;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    count_display #(.SCAN_DIV(4), .DONE_STRETCH(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .count    (count),
        .done     (done),
        .seg      (seg),
        .an       (an),
        .done_led (done_led),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect busy on the 9 samples following the sampling edge, then low.
    task automatic conv_wait(input string tag);
        tick();
        for (int i = 0; i < 9; i++) begin
            chk({tag, "_busy"}, busy, 1'b1);
            tick();
        end
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    // Sync to the start of digit 0, then check 4 digits each held 4 cycles.
    task automatic scan_chk(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] es [4];
        logic [3:0] ea [4];
        es[0] = s0; es[1] = s1; es[2] = s2; es[3] = s3;
        ea[0] = 4'hE; ea[1] = 4'hD; ea[2] = 4'hB; ea[3] = 4'h7;
        for (int i = 0; i < 20 && an == 4'hE; i++) tick();
        for (int i = 0; i < 20 && an != 4'hE; i++) tick();
        chk({tag, "_sync"}, an, 4'hE);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_an"}, an, ea[d]);
                chk({tag, "_seg"}, seg, es[d]);
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1; count = 8'd0; done = 1'b0;
        tick(); tick();
        chk("rst_seg", seg, 7'h7F);
        chk("rst_an", an, 4'hF);
        chk("rst_led", done_led, 1'b0);
        chk("rst_busy", busy, 1'b0);

        rst = 1'b0;
        tick();
        chk("first_an", an, 4'hE);
        for (int i = 0; i < 9; i++) begin
            chk("zero_busy", busy, 1'b1);
            tick();
        end
        chk("zero_idle", busy, 1'b0);
        scan_chk("zero", 7'h40, 7'h7F, 7'h7F, 7'h7F);

`ifndef COUNTDISP_SIGNED_EN
        count = 8'd255;
        conv_wait("c255");
        scan_chk("c255", 7'h12, 7'h12, 7'h24, 7'h7F);
`endif

        // 37 then 38 while busy: 37 lands first, 38 ten cycles later.
        count = 8'd37;
        tick();
        chk("c37_busy", busy, 1'b1);
        count = 8'd38;
        for (int i = 0; i < 8; i++) tick();
        chk("c37_still", busy, 1'b1);
        tick();
        chk("c37_upd", busy, 1'b0);
        chk("c37_ones", dut.disp[0], 7'h78);
        chk("c37_tens", dut.disp[1], 7'h30);
        tick();
        chk("c38_resample", busy, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        chk("c38_still", busy, 1'b1);
        tick();
        chk("c38_upd", busy, 1'b0);
        chk("c38_ones", dut.disp[0], 7'h00);
        scan_chk("c38", 7'h00, 7'h30, 7'h7F, 7'h7F);

        // Single done pulse: 6 cycles high.
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("pulse_hi", done_led, 1'b1);
            tick();
        end
        chk("pulse_lo", done_led, 1'b0);

        // Retrigger on the 4th high cycle: high for 9 cycles.
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("retrig_hi", done_led, 1'b1);
        tick();
        chk("retrig_hi", done_led, 1'b1);
        tick();
        chk("retrig_hi", done_led, 1'b1);
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("retrig_hi", done_led, 1'b1);
            tick();
        end
        chk("retrig_lo", done_led, 1'b0);

        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("cont_hi", done_led, 1'b1);
        end
        done = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("cont_lo", done_led, 1'b0);

`ifdef COUNTDISP_SIGNED_EN
        count = 8'h80;
        conv_wait("m128");
        scan_chk("m128", 7'h00, 7'h24, 7'h79, 7'h3F);
        count = 8'hFF;
        conv_wait("m1");
        scan_chk("m1", 7'h79, 7'h7F, 7'h7F, 7'h3F);
`endif

        // Reset on the 4th CONVERT cycle of 99, then a fresh conversion.
        count = 8'd99;
        tick();
        chk("c99_busy", busy, 1'b1);
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_seg", seg, 7'h7F);
        chk("mrst_an", an, 4'hF);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_led", done_led, 1'b0);
        rst = 1'b0;
        conv_wait("c99");
        scan_chk("c99", 7'h10, 7'h10, 7'h7F, 7'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
